// File: rtl/motor_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : motor_cmd_arbiter
// Brief    : Grants the motor speed datapath to PLC or HMI and slews speed
//            toward the owner's command. Speed ramps to zero before ownership
//            is handed over. Defining MOTOR_ARB_WDOG_EN adds the keep-alive
//            watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module motor_cmd_arbiter #(
    parameter int TICK_DIV   = 16,
    parameter int RAMP_STEP  = 16,
    parameter int WDOG_TICKS = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       estop,
    input  logic       plc_req,
    input  logic [3:0] plc_accel,
    input  logic [3:0] plc_brake,
    input  logic       plc_alive,
    input  logic       hmi_req,
    input  logic [3:0] hmi_accel,
    input  logic [3:0] hmi_brake,
    input  logic       hmi_alive,
    output logic       plc_gnt,
    output logic       hmi_gnt,
    output logic [7:0] speed,
    output logic [1:0] state,
    output logic       wdog_flag
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_RAMPDN = 2'd2,
        ST_ESTOP  = 2'd3
    } state_t;

    localparam int              c_PW        = $clog2(TICK_DIV);
    localparam logic [c_PW-1:0] c_PRESC_MAX = c_PW'(TICK_DIV - 1);
    localparam logic [8:0]      c_STEP      = 9'(RAMP_STEP);

    state_t          r_state, w_state_nxt;
    logic [c_PW-1:0] r_presc, w_presc_nxt, w_presc_run;
    logic [7:0]      r_speed, w_speed_nxt;
    logic            r_plc_gnt, w_plc_gnt_nxt;
    logic            r_hmi_gnt, w_hmi_gnt_nxt;
    logic            r_last_hmi, w_last_hmi_nxt;
    logic            w_tick, w_owner_req, w_pick_hmi, w_expired;
    logic            w_grant, w_wdog_trip;
    logic [3:0]      w_accel, w_brake, w_diff;
    logic [7:0]      w_target;
    logic [8:0]      w_sum_up, w_gap_dn;

    assign w_tick      = (r_presc == c_PRESC_MAX);
    assign w_presc_run = w_tick ? '0 : r_presc + 1'b1;
    assign w_owner_req = r_hmi_gnt ? hmi_req   : plc_req;
    assign w_accel     = r_hmi_gnt ? hmi_accel : plc_accel;
    assign w_brake     = r_hmi_gnt ? hmi_brake : plc_brake;
    assign w_diff      = w_accel - w_brake;
    assign w_target    = (w_accel > w_brake) ? {w_diff, 4'b0000} : 8'd0;
    assign w_sum_up    = {1'b0, r_speed} + c_STEP;
    assign w_gap_dn    = {1'b0, r_speed} - {1'b0, w_target};
    // r_last_hmi resets high so the PLC wins the first tie
    assign w_pick_hmi  = hmi_req && (!plc_req || !r_last_hmi);

    always_comb begin
        w_state_nxt    = r_state;
        w_presc_nxt    = r_presc;
        w_speed_nxt    = r_speed;
        w_plc_gnt_nxt  = r_plc_gnt;
        w_hmi_gnt_nxt  = r_hmi_gnt;
        w_last_hmi_nxt = r_last_hmi;
        w_grant        = 1'b0;
        w_wdog_trip    = 1'b0;
        if (estop) begin
            w_state_nxt   = ST_ESTOP;
            w_presc_nxt   = '0;
            w_speed_nxt   = 8'd0;
            w_plc_gnt_nxt = 1'b0;
            w_hmi_gnt_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_presc_nxt = '0;
                    if (plc_req || hmi_req) begin
                        w_grant        = 1'b1;
                        w_state_nxt    = ST_RUN;
                        w_plc_gnt_nxt  = !w_pick_hmi;
                        w_hmi_gnt_nxt  = w_pick_hmi;
                        w_last_hmi_nxt = w_pick_hmi;
                    end
                end
                ST_RUN: begin
                    w_presc_nxt = w_presc_run;
                    // Losing ownership takes precedence over a coincident tick
                    if (!w_owner_req || w_expired) begin
                        w_wdog_trip   = w_owner_req;
                        w_plc_gnt_nxt = 1'b0;
                        w_hmi_gnt_nxt = 1'b0;
                        if (r_speed == 8'd0) begin
                            w_state_nxt = ST_IDLE;
                            w_presc_nxt = '0;
                        end else begin
                            w_state_nxt = ST_RAMPDN;
                        end
                    end else if (w_tick) begin
                        if (r_speed < w_target)
                            w_speed_nxt = (w_sum_up > {1'b0, w_target}) ? w_target : w_sum_up[7:0];
                        else if (r_speed > w_target)
                            w_speed_nxt = (w_gap_dn <= c_STEP) ? w_target : r_speed - c_STEP[7:0];
                    end
                end
                ST_RAMPDN: begin
                    w_presc_nxt = w_presc_run;
                    if (w_tick) begin
                        if ({1'b0, r_speed} <= c_STEP) begin
                            w_speed_nxt = 8'd0;
                            w_state_nxt = ST_IDLE;
                            w_presc_nxt = '0;
                        end else begin
                            w_speed_nxt = r_speed - c_STEP[7:0];
                        end
                    end
                end
                default: begin
                    w_presc_nxt = '0;
                    if (!plc_req && !hmi_req)
                        w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_presc    <= '0;
            r_speed    <= 8'd0;
            r_plc_gnt  <= 1'b0;
            r_hmi_gnt  <= 1'b0;
            r_last_hmi <= 1'b1;
        end else if (ena) begin
            r_state    <= w_state_nxt;
            r_presc    <= w_presc_nxt;
            r_speed    <= w_speed_nxt;
            r_plc_gnt  <= w_plc_gnt_nxt;
            r_hmi_gnt  <= w_hmi_gnt_nxt;
            r_last_hmi <= w_last_hmi_nxt;
        end
    end

`ifdef MOTOR_ARB_WDOG_EN
    localparam int              c_WW       = $clog2(WDOG_TICKS + 1);
    localparam logic [c_WW-1:0] c_WDOG_LIM = c_WW'(WDOG_TICKS);

    logic [c_WW-1:0] r_wdog_cnt, w_wdog_inc;
    logic            r_wdog_flag, w_owner_alive;

    assign w_owner_alive = r_hmi_gnt ? hmi_alive : plc_alive;
    assign w_wdog_inc    = r_wdog_cnt + 1'b1;
    assign w_expired     = w_tick && !w_owner_alive && (w_wdog_inc >= c_WDOG_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog_cnt  <= '0;
            r_wdog_flag <= 1'b0;
        end else if (ena) begin
            if (w_grant) begin
                r_wdog_cnt  <= '0;
                r_wdog_flag <= 1'b0;
            end else begin
                if (r_state == ST_RUN) begin
                    if (w_owner_alive)
                        r_wdog_cnt <= '0;
                    else if (w_tick)
                        r_wdog_cnt <= w_wdog_inc;
                end
                if (w_wdog_trip)
                    r_wdog_flag <= 1'b1;
            end
        end
    end

    assign wdog_flag = r_wdog_flag;
`else
    logic w_unused_wdog;

    assign w_expired     = 1'b0;
    assign wdog_flag     = 1'b0;
    assign w_unused_wdog = ^{plc_alive, hmi_alive, w_grant, w_wdog_trip};
`endif

    assign plc_gnt = r_plc_gnt;
    assign hmi_gnt = r_hmi_gnt;
    assign speed   = r_speed;
    assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_motor_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_cmd_arbiter
// Brief    : Directed plus randomized bench for motor_cmd_arbiter against a
//            behavioural model of ownership, ticks and speed slewing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_cmd_arbiter;

    localparam int TICK_DIV   = 3;
    localparam int RAMP_STEP  = 36;
    localparam int WDOG_TICKS = 4;
`ifdef MOTOR_ARB_WDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, ena, estop;
    logic       plc_req, hmi_req, plc_alive, hmi_alive;
    logic [3:0] plc_accel, plc_brake, hmi_accel, hmi_brake;
    logic       plc_gnt, hmi_gnt, wdog_flag;
    logic [7:0] speed;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    // Model: state code, owner (0 none, 1 PLC, 2 HMI), last owner, speed,
    // enabled cycles within the current tick period, watchdog ticks, flag.
    int m_state, m_owner, m_last, m_speed, m_phase, m_wd;
    bit m_flag;

    motor_cmd_arbiter #(
        .TICK_DIV   (TICK_DIV),
        .RAMP_STEP  (RAMP_STEP),
        .WDOG_TICKS (WDOG_TICKS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .estop     (estop),
        .plc_req   (plc_req),
        .plc_accel (plc_accel),
        .plc_brake (plc_brake),
        .plc_alive (plc_alive),
        .hmi_req   (hmi_req),
        .hmi_accel (hmi_accel),
        .hmi_brake (hmi_brake),
        .hmi_alive (hmi_alive),
        .plc_gnt   (plc_gnt),
        .hmi_gnt   (hmi_gnt),
        .speed     (speed),
        .state     (state),
        .wdog_flag (wdog_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_owner = 0; m_last = 2; m_speed = 0;
        m_phase = 0; m_wd = 0; m_flag = 1'b0;
    endtask

    task automatic model_step();
        bit tick, oreq, oalive;
        int acc, brk, tgt;
        if (!ena) return;
        if (estop) begin
            m_state = 3; m_speed = 0; m_owner = 0; m_phase = 0;
            return;
        end
        tick = (m_phase == TICK_DIV - 1);
        case (m_state)
            0: if (plc_req || hmi_req) begin
                if (plc_req && hmi_req) m_owner = (m_last == 1) ? 2 : 1;
                else                    m_owner = plc_req ? 1 : 2;
                m_last = m_owner; m_state = 1; m_phase = 0; m_flag = 1'b0; m_wd = 0;
            end
            1: begin
                m_phase = (m_phase + 1) % TICK_DIV;
                oreq   = (m_owner == 1) ? plc_req   : hmi_req;
                oalive = (m_owner == 1) ? plc_alive : hmi_alive;
                acc    = (m_owner == 1) ? int'(plc_accel) : int'(hmi_accel);
                brk    = (m_owner == 1) ? int'(plc_brake) : int'(hmi_brake);
                if (oalive) m_wd = 0;
                else if (tick) m_wd++;
                if (!oreq || (WD_EN && m_wd >= WDOG_TICKS)) begin
                    if (oreq) m_flag = 1'b1;
                    m_owner = 0;
                    if (m_speed == 0) begin m_state = 0; m_phase = 0; end
                    else m_state = 2;
                end else if (tick) begin
                    tgt = (acc > brk) ? (acc - brk) * 16 : 0;
                    if (m_speed < tgt)
                        m_speed = (m_speed + RAMP_STEP > tgt) ? tgt : m_speed + RAMP_STEP;
                    else if (m_speed > tgt)
                        m_speed = (m_speed - RAMP_STEP < tgt) ? tgt : m_speed - RAMP_STEP;
                end
            end
            2: begin
                m_phase = (m_phase + 1) % TICK_DIV;
                if (tick) begin
                    m_speed = (m_speed > RAMP_STEP) ? m_speed - RAMP_STEP : 0;
                    if (m_speed == 0) begin m_state = 0; m_phase = 0; end
                end
            end
            default: if (!plc_req && !hmi_req) m_state = 0;
        endcase
    endtask

    // One clock: advance the model at the edge, compare on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step();
        @(negedge clk);
        check("state", state, m_state);
        check("speed", speed, m_speed);
        check("plc_gnt", plc_gnt, m_owner == 1);
        check("hmi_gnt", hmi_gnt, m_owner == 2);
        check("wdog_flag", wdog_flag, m_flag);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; estop = 1'b0;
        plc_req = 1'b0; hmi_req = 1'b0; plc_alive = 1'b1; hmi_alive = 1'b1;
        plc_accel = 4'd0; plc_brake = 4'd0; hmi_accel = 4'd0; hmi_brake = 4'd0;
        model_reset();
        repeat (2) cycle();
        check("lit_rst_state", state, 0);
        check("lit_rst_speed", speed, 0);
        check("lit_rst_gnt", {plc_gnt, hmi_gnt, wdog_flag}, 0);

        // Single requester: grant after one edge, first tick TICK_DIV later
        rst_n = 1'b1; plc_req = 1'b1; plc_accel = 4'd5; plc_brake = 4'd2;
        cycle();
        check("lit_grant_plc", plc_gnt, 1);
        check("lit_grant_state", state, 1);
        repeat (2) cycle();
        check("lit_pre_tick", speed, 0);
        cycle();
        check("lit_tick1", speed, 36);
        repeat (3) cycle();
        check("lit_tick2_clamp", speed, 48);
        repeat (6) cycle();
        check("lit_hold48", speed, 48);

        // Release, requests ignored during ramp-down, then round robin
        plc_req = 1'b0;
        cycle();
        check("lit_rel_state", state, 2);
        check("lit_rel_gnt", plc_gnt, 0);
        check("lit_rel_speed", speed, 48);
        plc_req = 1'b1; hmi_req = 1'b1; hmi_accel = 4'd15; hmi_brake = 4'd0;
        repeat (2) cycle();
        check("lit_rampdn12", speed, 12);
        check("lit_rampdn_state", state, 2);
        repeat (3) cycle();
        check("lit_idle_speed", speed, 0);
        check("lit_idle_state", state, 0);
        cycle();
        check("lit_rr_hmi", hmi_gnt, 1);
        check("lit_rr_plc", plc_gnt, 0);

        // Emergency stop
        repeat (9) cycle();
        check("lit_hmi_108", speed, 108);
        estop = 1'b1;
        cycle();
        estop = 1'b0; plc_req = 1'b0;
        check("lit_estop_speed", speed, 0);
        check("lit_estop_state", state, 3);
        check("lit_estop_gnt", hmi_gnt, 0);
        repeat (3) cycle();
        check("lit_estop_hold", state, 3);
        hmi_req = 1'b0;
        cycle();
        check("lit_estop_exit", state, 0);

        // Saturation at 240, ramp down to zero target, ena freeze
        plc_req = 1'b1; plc_accel = 4'd15; plc_brake = 4'd0;
        cycle();
        repeat (18) cycle();
        check("lit_sat216", speed, 216);
        repeat (3) cycle();
        check("lit_sat240", speed, 240);
        repeat (3) cycle();
        check("lit_sat_hold", speed, 240);
        plc_accel = 4'd3; plc_brake = 4'd7;
        repeat (3) cycle();
        check("lit_down204", speed, 204);
        ena = 1'b0;
        repeat (40) cycle();
        check("lit_frozen", speed, 204);
        ena = 1'b1;
        repeat (3) cycle();
        check("lit_resume168", speed, 168);
        repeat (15) cycle();
        check("lit_zero_speed", speed, 0);
        check("lit_zero_run", state, 1);

        // Keep-alive withdrawn for WDOG_TICKS ticks
        plc_accel = 4'd5; plc_brake = 4'd2; plc_alive = 1'b0; hmi_alive = 1'b0;
        repeat (12) cycle();
        check("lit_wd_speed", speed, 48);
`ifdef MOTOR_ARB_WDOG_EN
        check("lit_wd_state", state, 2);
        check("lit_wd_flag", wdog_flag, 1);
        check("lit_wd_gnt", plc_gnt, 0);
`else
        check("lit_wd_state", state, 1);
        check("lit_wd_flag", wdog_flag, 0);
        check("lit_wd_gnt", plc_gnt, 1);
`endif

        // Randomized traffic with a mid-run reset
        plc_req = 1'b0; hmi_req = 1'b0;
        for (int i = 0; i < 8000; i++) begin
            ena   = ($urandom_range(15) != 0);
            estop = ($urandom_range(499) == 0);
            if ($urandom_range(49) == 0) plc_req = ~plc_req;
            if ($urandom_range(49) == 0) hmi_req = ~hmi_req;
            if ($urandom_range(19) == 0) plc_accel = 4'($urandom_range(15));
            if ($urandom_range(19) == 0) plc_brake = 4'($urandom_range(15));
            if ($urandom_range(19) == 0) hmi_accel = 4'($urandom_range(15));
            if ($urandom_range(19) == 0) hmi_brake = 4'($urandom_range(15));
            plc_alive = ($urandom_range(5) == 0);
            hmi_alive = ($urandom_range(5) == 0);
            if (i == 4000) rst_n = 1'b0;
            if (i == 4003) rst_n = 1'b1;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/motor_cmd_arbiter.md
# motor_cmd_arbiter

Shares the motor-speed datapath between the PLC and HMI command sources. The block grants exactly one source at a time and converts the granted accelerator/brake nibbles into a speed target. It slews the 8-bit motor speed toward that target at a fixed ramp rate, then ramps to zero before handing ownership to the other source. It sits between the operator/PLC input decode and the motor speed output register, and adds emergency stop and an optional command watchdog.

## Interface
- TICK_DIV, 16: enabled clock cycles per ramp tick (≥2)
- RAMP_STEP, 16: speed change per tick (1..255)
- WDOG_TICKS, 64: ramp ticks without an owner alive pulse before timeout (watchdog build only)

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  global enable; low freezes all state, including the prescaler
- estop  in  1  emergency stop, level-sensitive
- plc_req / hmi_req  in  1  source requests ownership; hold high while commanding
- plc_accel / hmi_accel  in  4  accelerator command
- plc_brake / hmi_brake  in  4  brake command
- plc_alive / hmi_alive  in  1  keep-alive pulse; used only with the watchdog
- plc_gnt / hmi_gnt  out  1  registered, one-hot-or-zero grant
- speed  out  8  current motor speed
- state  out  2  0 IDLE, 1 RUN, 2 RAMPDN, 3 ESTOP
- wdog_flag  out  1  sticky watchdog timeout

## Operation
- Reset values: every output is 0. The round-robin pointer is reset so that PLC wins the first tie.
- IDLE (speed is 0):
  - If exactly one source requests, grant it.
  - If both request, grant the source not granted last.
  - On granting, go to RUN, clear the prescaler, and clear wdog_flag.
- RUN:
  - target = (accel > brake) ? (accel − brake) << 4 : 0, taken from the owner's inputs every cycle. Maximum is 240.
  - On each tick, if speed < target: speed = min(speed + RAMP_STEP, target), computed 9-bit with no wrap.
  - On each tick, if speed > target: speed = max(speed − RAMP_STEP, target), computed with no underflow.
  - If the owner drops its req, go to RAMPDN and drop the grant in the same update.
- RAMPDN:
  - No grant is held. On each tick, speed = max(speed − RAMP_STEP, 0).
  - On the update where speed is 0, go to IDLE.
  - If RUN is left with speed already 0, go straight to IDLE.
  - Requests arriving during RAMPDN are ignored until IDLE.
- ESTOP:
  - estop high in any state forces, on the next edge: speed 0, both grants 0, state ESTOP.
  - estop has priority over every other event.
  - Leave ESTOP to IDLE only when estop is low and both reqs are low on the same cycle.
- ena low: all registers hold. estop is not sampled while ena is low.
- The prescaler counts 0..TICK_DIV−1 on enabled cycles. A tick is the cycle where it equals TICK_DIV−1. The prescaler runs in RUN and RAMPDN and is cleared in IDLE/ESTOP.

## Timing
- Grant latency: req sampled high in IDLE leads to gnt high on the next edge.
- First speed update: TICK_DIV enabled cycles after the grant edge. Subsequent updates occur every TICK_DIV cycles.
- Ramp from 0 to target T takes ceil(T/RAMP_STEP) ticks.
- Release: req low leads to gnt low on the next edge. The other source can be granted at the earliest 1 cycle after speed reaches 0.
- estop to speed 0 and gnts 0 is 1 cycle.
- A tick and an req drop in the same cycle: apply the state change. The RAMPDN decrement starts on the next tick.

## Configuration
- MOTOR_ARB_WDOG_EN defined:
  - A counter of ticks in RUN is cleared by the owner's alive pulse.
  - Reaching WDOG_TICKS forces RAMPDN, drops the grant, and sets wdog_flag.
  - wdog_flag stays set until the next grant.
- Not defined:
  - The alive inputs are ignored and wdog_flag is constantly 0.
  - The only exits from RUN are owner release and estop.

## Test plan
- Reset, then plc_req=1, accel=5, brake=2 → plc_gnt at cycle 1. speed steps 16/32/48 at cycles 17/33/49, then holds at 48.
- Both reqs high from reset → plc_gnt. Drop plc_req at speed 48 → speed steps to 32/16/0, then IDLE. Both reqs high again → hmi_gnt (round robin).
- Owner at speed 96, estop pulse → next cycle speed=0, state=3, gnts 0. Holding hmi_req keeps ESTOP. Dropping it → IDLE.
- accel=3, brake=7 while at speed 48 → ramps down to 0 and stays in RUN. ena held low for 40 cycles mid-ramp → speed and prescaler frozen.
- TICK_DIV=2, RAMP_STEP=255, accel=15, brake=0 → speed 240 on the first tick (saturation, no overshoot).
- With MOTOR_ARB_WDOG_EN and WDOG_TICKS=4, no alive pulses → after 4 ticks gnt drops, state=2, and wdog_flag=1 until the next grant. Without the macro → stays in RUN and wdog_flag=0.
